engine_array_scheduler: RTL and testbench
=========================================

Name: engine_array_scheduler

Overview:
- Multi-engine successor to the single Smith-Waterman engine top level.
- Sits between the stream input handler and NUM_ENGINES engine cores, all on one clock.
- Dispatches each query (descriptor plus query sequence blocks) to an idle engine, chosen round-robin.
- Merges the engines' cell-score result records into one output stream; records are never interleaved.

Parameters:
- NUM_ENGINES, 4, number of engine channels (2..16).
- QBLK_W, 128, query sequence block width (2*NUM_PES).
- RES_W, 128, result word width.
- ENG_IDX_W, $clog2(NUM_ENGINES), localparam: engine index width.

Ports:
- clk  in  1  engine clock
- rst  in  1  synchronous active-high reset
- q_info_in  in  120  query descriptor: [119:92] ref_length, [91:64] ref_addr, [63:48] num_query_blocks, [47:32] query_id, [31:0] cell_score_threshold
- q_info_valid_in  in  1  descriptor valid
- q_info_rdy_out  out  1  descriptor accepted
- q_blk_in  in  QBLK_W  query sequence block
- q_blk_valid_in  in  1  block valid
- q_blk_rdy_out  out  1  block accepted
- eng_info_out  out  120  registered descriptor, broadcast to all engines
- eng_info_valid_out  out  NUM_ENGINES  one-hot descriptor valid
- eng_info_rdy_in  in  NUM_ENGINES  per-engine descriptor ready
- eng_blk_out  out  QBLK_W  broadcast query block
- eng_blk_valid_out  out  NUM_ENGINES  one-hot block valid
- eng_blk_rdy_in  in  NUM_ENGINES  per-engine block ready
- eng_done_in  in  NUM_ENGINES  one-cycle pulse: engine finished its query
- eng_res_in  in  NUM_ENGINES*RES_W  result words, engine i at [i*RES_W +: RES_W]
- eng_res_valid_in  in  NUM_ENGINES  result valid
- eng_res_last_in  in  NUM_ENGINES  last word of a record
- eng_res_rdy_out  out  NUM_ENGINES  result accepted
- res_out  out  RES_W  merged result word
- res_valid_out  out  1  merged valid
- res_last_out  out  1  merged last
- res_eng_out  out  ENG_IDX_W  source engine of the current word
- res_rdy_in  in  1  downstream ready
- busy_out  out  NUM_ENGINES  engine-busy flags
- stat_sel_in  in  ENG_IDX_W  statistics select
- stat_cnt_out  out  32  statistics value

Behaviour:
- Reset: all valid, rdy and busy outputs are 0; the FSM enters D_IDLE; rr pointers are 0; counters are 0. A reset mid-transfer abandons the transfer with no flush.
- Dispatch FSM, D_IDLE:
  - q_info_rdy_out = q_info_valid_in && (~busy != 0).
  - On handshake: register the descriptor and set sel = the first non-busy engine at or after disp_rr, searching with wrap. Go to D_INFO.
- Dispatch FSM, D_INFO:
  - eng_info_valid_out[sel] = 1.
  - On eng_info_rdy_in[sel]: set busy[sel], load blk_cnt (16 bit) = num_query_blocks, set disp_rr = sel+1 mod NUM_ENGINES.
  - Go to D_IDLE if num_query_blocks == 0, otherwise D_BLK.
- Dispatch FSM, D_BLK:
  - Combinational pass-through: eng_blk_valid_out[sel] = q_blk_valid_in, q_blk_rdy_out = eng_blk_rdy_in[sel], eng_blk_out = q_blk_in.
  - Each handshake decrements blk_cnt. The handshake taken at blk_cnt == 1 returns the FSM to D_IDLE.
  - q_blk_rdy_out = 0 in every other state.
- Busy flags:
  - eng_done_in[i] clears busy[i]. A done pulse on an idle engine is ignored.
  - A done pulse for engine i in the same cycle as a dispatch to engine j (j != i) applies both.
  - An engine freed by a done pulse is selectable the next cycle.
- Merge arbiter:
  - When unlocked: grant = the first valid engine at or after merge_rr.
  - When locked: grant is held until a word with last=1 is accepted; merge_rr then becomes grant+1.
  - Zero-latency mux: res_out, res_last_out, res_valid_out and res_eng_out reflect the granted engine. eng_res_rdy_out[grant] = res_rdy_in; all other ready bits are 0.
  - The arbiter locks on the first accepted word whose last bit is 0. A single-word record (last=1) never locks.
- Dispatch and merge run concurrently and independently.

Optional Feature:
- Macro ENGINE_ARRAY_STATS_EN.
- Defined: one 32-bit wrapping counter per engine, incremented on each descriptor handshake to that engine. stat_cnt_out = counter[stat_sel_in], registered (1-cycle latency). rst clears all counters.
- Undefined: no counters; stat_cnt_out is tied to 0.

Decomposition:
- Package engine_array_pkg holds:
  - INFO_W=120.
  - Field offset/width constants (REF_LEN_LSB, REF_ADDR_LSB, NQB_LSB, QID_LSB, THR_LSB).
  - The dispatch-state enum {D_IDLE, D_INFO, D_BLK}.
- One sub-module: rr_arbiter (parametrised request vector and pointer in, one-hot grant plus index out). It is instantiated for both engine selection and result merging.

Test Plan:
- Dispatch: 3 descriptors with num_query_blocks=2, all engines idle → engines 0, 1, 2 are selected in order. Each receives exactly 2 blocks; busy_out=4'b0111.
- Saturation: all 4 engines busy, 5th descriptor valid → q_info_rdy_out stays 0. A done pulse on engine 2 → dispatch to engine 2 the next cycle.
- Zero-block query: num_query_blocks=0 → info handshake only, no blocks forwarded, FSM returns to D_IDLE. With eng_info_rdy_in delayed 5 cycles, eng_info_valid_out holds.
- Merge: engines 1 and 3 each send a 4-word record simultaneously; res_rdy_in toggles 50% → output is 4 contiguous words from engine 1 (res_eng_out=1), then 4 from engine 3. No interleaving; res_last_out is set only on words 4 and 8.
- Reset in D_BLK after 1 of 3 blocks → all valid/rdy outputs are 0 the next cycle, busy_out=0. A new query then dispatches to engine 0.
- With ENGINE_ARRAY_STATS_EN: 6 dispatches across 4 engines → stat_sel_in=0 reads 2 and stat_sel_in=3 reads 1, one cycle after select.

Source files
------------

// File: rtl/engine_array_pkg.sv
// Shared descriptor layout, dispatch-state type and index helper for the engine array scheduler.
package engine_array_pkg;

    localparam int unsigned INFO_W = 120;

    localparam int unsigned REF_LEN_LSB  = 92;
    localparam int unsigned REF_LEN_W    = 28;
    localparam int unsigned REF_ADDR_LSB = 64;
    localparam int unsigned REF_ADDR_W   = 28;
    localparam int unsigned NQB_LSB      = 48;
    localparam int unsigned NQB_W        = 16;
    localparam int unsigned QID_LSB      = 32;
    localparam int unsigned QID_W        = 16;
    localparam int unsigned THR_LSB      = 0;
    localparam int unsigned THR_W        = 32;

    typedef enum logic [1:0] {
        D_IDLE,
        D_INFO,
        D_BLK
    } disp_state_e;

    // Next engine index with wrap-around, for round-robin pointers.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, searching with wrap.
module rr_arbiter #(
    parameter int unsigned  N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % N);
            if (!valid_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/engine_array_scheduler.sv
// Dispatches queries to idle engines round-robin and merges their result records without
// interleaving. Define ENGINE_ARRAY_STATS_EN to add per-engine dispatch counters.
module engine_array_scheduler
    import engine_array_pkg::*;
#(
    parameter int unsigned  NUM_ENGINES = 4,
    parameter int unsigned  QBLK_W      = 128,
    parameter int unsigned  RES_W       = 128,
    localparam int unsigned ENG_IDX_W   = $clog2(NUM_ENGINES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INFO_W-1:0]            q_info_in,
    input  logic                         q_info_valid_in,
    output logic                         q_info_rdy_out,
    input  logic [QBLK_W-1:0]            q_blk_in,
    input  logic                         q_blk_valid_in,
    output logic                         q_blk_rdy_out,
    output logic [INFO_W-1:0]            eng_info_out,
    output logic [NUM_ENGINES-1:0]       eng_info_valid_out,
    input  logic [NUM_ENGINES-1:0]       eng_info_rdy_in,
    output logic [QBLK_W-1:0]            eng_blk_out,
    output logic [NUM_ENGINES-1:0]       eng_blk_valid_out,
    input  logic [NUM_ENGINES-1:0]       eng_blk_rdy_in,
    input  logic [NUM_ENGINES-1:0]       eng_done_in,
    input  logic [NUM_ENGINES*RES_W-1:0] eng_res_in,
    input  logic [NUM_ENGINES-1:0]       eng_res_valid_in,
    input  logic [NUM_ENGINES-1:0]       eng_res_last_in,
    output logic [NUM_ENGINES-1:0]       eng_res_rdy_out,
    output logic [RES_W-1:0]             res_out,
    output logic                         res_valid_out,
    output logic                         res_last_out,
    output logic [ENG_IDX_W-1:0]         res_eng_out,
    input  logic                         res_rdy_in,
    output logic [NUM_ENGINES-1:0]       busy_out,
    input  logic [ENG_IDX_W-1:0]         stat_sel_in,
    output logic [31:0]                  stat_cnt_out
);

    // ---------------------------------------------------------------- dispatch
    disp_state_e            state_q, state_d;
    logic [ENG_IDX_W-1:0]   sel_q, sel_d;
    logic [ENG_IDX_W-1:0]   disp_rr_q, disp_rr_d;
    logic [INFO_W-1:0]      info_q, info_d;
    logic [NUM_ENGINES-1:0] busy_q, busy_d;
    logic [NQB_W-1:0]       blk_cnt_q, blk_cnt_d;
    logic [NUM_ENGINES-1:0] sel_oh;
    logic [NUM_ENGINES-1:0] dispatch_set;
    logic                   info_hs;

    logic [NUM_ENGINES-1:0] free_gnt;
    logic [ENG_IDX_W-1:0]   free_idx;
    logic                   free_any;

    rr_arbiter #(
        .N (NUM_ENGINES)
    ) u_disp_arb (
        .req_i   (~busy_q),
        .ptr_i   (disp_rr_q),
        .gnt_o   (free_gnt),
        .idx_o   (free_idx),
        .valid_o (free_any)
    );

    always_comb begin
        sel_oh        = '0;
        sel_oh[sel_q] = 1'b1;
    end

    always_comb begin
        state_d            = state_q;
        sel_d              = sel_q;
        info_d             = info_q;
        blk_cnt_d          = blk_cnt_q;
        disp_rr_d          = disp_rr_q;
        dispatch_set       = '0;
        info_hs            = 1'b0;
        q_info_rdy_out     = 1'b0;
        q_blk_rdy_out      = 1'b0;
        eng_info_valid_out = '0;
        eng_blk_valid_out  = '0;

        unique case (state_q)
            D_IDLE: begin
                q_info_rdy_out = q_info_valid_in && free_any;
                if (q_info_valid_in && free_any) begin
                    info_d  = q_info_in;
                    sel_d   = free_idx;
                    state_d = D_INFO;
                end
            end
            D_INFO: begin
                eng_info_valid_out = sel_oh;
                if (eng_info_rdy_in[sel_q]) begin
                    info_hs      = 1'b1;
                    dispatch_set = sel_oh;
                    blk_cnt_d    = info_q[NQB_LSB +: NQB_W];
                    disp_rr_d    = ENG_IDX_W'(wrap_inc(32'(sel_q), NUM_ENGINES));
                    state_d      = (info_q[NQB_LSB +: NQB_W] == '0) ? D_IDLE : D_BLK;
                end
            end
            D_BLK: begin
                eng_blk_valid_out = q_blk_valid_in ? sel_oh : '0;
                q_blk_rdy_out     = eng_blk_rdy_in[sel_q];
                if (q_blk_valid_in && eng_blk_rdy_in[sel_q]) begin
                    blk_cnt_d = blk_cnt_q - 1'b1;
                    if (blk_cnt_q == NQB_W'(1)) begin
                        state_d = D_IDLE;
                    end
                end
            end
            default: state_d = D_IDLE;
        endcase

        // A done pulse and a dispatch to another engine in the same cycle both take effect.
        busy_d = (busy_q & ~eng_done_in) | dispatch_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= D_IDLE;
            sel_q     <= '0;
            disp_rr_q <= '0;
            info_q    <= '0;
            busy_q    <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            disp_rr_q <= disp_rr_d;
            info_q    <= info_d;
            busy_q    <= busy_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign eng_info_out = info_q;
    assign eng_blk_out  = q_blk_in;
    assign busy_out     = busy_q;

    // ------------------------------------------------------------------- merge
    logic [NUM_ENGINES-1:0] arb_gnt;
    logic [ENG_IDX_W-1:0]   arb_idx;
    logic                   arb_any;
    logic                   locked_q, locked_d;
    logic [ENG_IDX_W-1:0]   grant_q, grant_d;
    logic [ENG_IDX_W-1:0]   merge_rr_q, merge_rr_d;
    logic [ENG_IDX_W-1:0]   grant;
    logic                   granted;

    rr_arbiter #(
        .N (NUM_ENGINES)
    ) u_merge_arb (
        .req_i   (eng_res_valid_in),
        .ptr_i   (merge_rr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_any)
    );

    always_comb begin
        grant           = locked_q ? grant_q : arb_idx;
        granted         = locked_q || arb_any;
        res_valid_out   = granted && eng_res_valid_in[grant];
        res_last_out    = granted && eng_res_last_in[grant];
        res_out         = eng_res_in[32'(grant) * RES_W +: RES_W];
        res_eng_out     = grant;
        eng_res_rdy_out = '0;
        if (granted) begin
            eng_res_rdy_out[grant] = res_rdy_in;
        end

        locked_d   = locked_q;
        grant_d    = grant_q;
        merge_rr_d = merge_rr_q;
        // Lock only on a non-last word so single-word records never hold the output.
        if (res_valid_out && res_rdy_in) begin
            if (res_last_out) begin
                locked_d   = 1'b0;
                merge_rr_d = ENG_IDX_W'(wrap_inc(32'(grant), NUM_ENGINES));
            end else begin
                locked_d = 1'b1;
                grant_d  = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q   <= 1'b0;
            grant_q    <= '0;
            merge_rr_q <= '0;
        end else begin
            locked_q   <= locked_d;
            grant_q    <= grant_d;
            merge_rr_q <= merge_rr_d;
        end
    end

    // -------------------------------------------------------------- statistics
`ifdef ENGINE_ARRAY_STATS_EN
    logic [31:0] stat_cnt_q [NUM_ENGINES];
    logic [31:0] stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
                stat_cnt_q[i] <= '0;
            end
            stat_q <= '0;
        end else begin
            if (info_hs) begin
                stat_cnt_q[sel_q] <= stat_cnt_q[sel_q] + 32'd1;
            end
            stat_q <= (32'(stat_sel_in) < NUM_ENGINES) ? stat_cnt_q[stat_sel_in] : '0;
        end
    end

    assign stat_cnt_out = stat_q;
`else
    logic stat_unused;
    assign stat_unused  = ^{stat_sel_in, info_hs};
    assign stat_cnt_out = '0;
`endif

endmodule

// File: tb/tb_engine_array_scheduler.sv
// Bench for engine_array_scheduler: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model.
module tb_engine_array_scheduler;

    localparam int N      = 4;
    localparam int QBLK_W = 128;
    localparam int RES_W  = 128;
    localparam int IW     = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [119:0]       q_info_in;
    logic               q_info_valid_in;
    logic               q_info_rdy_out;
    logic [QBLK_W-1:0]  q_blk_in;
    logic               q_blk_valid_in;
    logic               q_blk_rdy_out;
    logic [119:0]       eng_info_out;
    logic [N-1:0]       eng_info_valid_out;
    logic [N-1:0]       eng_info_rdy_in;
    logic [QBLK_W-1:0]  eng_blk_out;
    logic [N-1:0]       eng_blk_valid_out;
    logic [N-1:0]       eng_blk_rdy_in;
    logic [N-1:0]       eng_done_in;
    logic [N*RES_W-1:0] eng_res_in;
    logic [N-1:0]       eng_res_valid_in;
    logic [N-1:0]       eng_res_last_in;
    logic [N-1:0]       eng_res_rdy_out;
    logic [RES_W-1:0]   res_out;
    logic               res_valid_out;
    logic               res_last_out;
    logic [IW-1:0]      res_eng_out;
    logic               res_rdy_in;
    logic [N-1:0]       busy_out;
    logic [IW-1:0]      stat_sel_in;
    logic [31:0]        stat_cnt_out;

    always #5 clk = ~clk;

    engine_array_scheduler #(
        .NUM_ENGINES (N),
        .QBLK_W      (QBLK_W),
        .RES_W       (RES_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .q_info_in          (q_info_in),
        .q_info_valid_in    (q_info_valid_in),
        .q_info_rdy_out     (q_info_rdy_out),
        .q_blk_in           (q_blk_in),
        .q_blk_valid_in     (q_blk_valid_in),
        .q_blk_rdy_out      (q_blk_rdy_out),
        .eng_info_out       (eng_info_out),
        .eng_info_valid_out (eng_info_valid_out),
        .eng_info_rdy_in    (eng_info_rdy_in),
        .eng_blk_out        (eng_blk_out),
        .eng_blk_valid_out  (eng_blk_valid_out),
        .eng_blk_rdy_in     (eng_blk_rdy_in),
        .eng_done_in        (eng_done_in),
        .eng_res_in         (eng_res_in),
        .eng_res_valid_in   (eng_res_valid_in),
        .eng_res_last_in    (eng_res_last_in),
        .eng_res_rdy_out    (eng_res_rdy_out),
        .res_out            (res_out),
        .res_valid_out      (res_valid_out),
        .res_last_out       (res_last_out),
        .res_eng_out        (res_eng_out),
        .res_rdy_in         (res_rdy_in),
        .busy_out           (busy_out),
        .stat_sel_in        (stat_sel_in),
        .stat_cnt_out       (stat_cnt_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 = waiting for a query, 1 = offering descriptor, 2 = blocks.
    int           m_phase, m_sel, m_cnt, m_drr;
    logic [N-1:0] m_busy;
    logic [119:0] m_desc;
    bit           m_locked;
    int           m_grant, m_mrr;
    int unsigned  m_stats [N];
    logic [31:0]  m_stat;

    // Observations of DUT traffic for directed scenario checks.
    logic [N-1:0]     acc_res;
    int               blk_seen [N];
    int               out_eng [$];
    logic             out_last [$];
    logic [RES_W-1:0] out_data [$];

    function automatic int first_from(input logic [N-1:0] req, input int start);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [119:0] mk_desc(input int nqb);
        return {28'($urandom), 28'($urandom), 16'(nqb), 16'($urandom), $urandom};
    endfunction

    task automatic m_reset();
        m_phase = 0; m_sel = 0; m_cnt = 0; m_drr = 0; m_busy = '0; m_desc = '0;
        m_locked = 0; m_grant = 0; m_mrr = 0; m_stat = '0;
        for (int i = 0; i < N; i++) m_stats[i] = 0;
    endtask

    task automatic idle_inputs();
        q_info_in = '0; q_info_valid_in = 0; q_blk_in = '0; q_blk_valid_in = 0;
        eng_info_rdy_in = '0; eng_blk_rdy_in = '0; eng_done_in = '0;
        eng_res_in = '0; eng_res_valid_in = '0; eng_res_last_in = '0;
        res_rdy_in = 0; stat_sel_in = '0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        int           g;
        logic [N-1:0] exp_v;
        logic [N-1:0] nb;
        bit           take_q;
        #3;
        g = m_locked ? m_grant : first_from(eng_res_valid_in, m_mrr);
        take_q = (m_phase == 0) && q_info_valid_in && (m_busy != '1);
        if (!rst) begin
            check("q_info_rdy", q_info_rdy_out, take_q);
            exp_v = '0;
            if (m_phase == 1) exp_v[m_sel] = 1'b1;
            check("eng_info_valid", eng_info_valid_out, exp_v);
            if (m_phase == 1) check("eng_info", eng_info_out, m_desc);
            exp_v = '0;
            if (m_phase == 2 && q_blk_valid_in) exp_v[m_sel] = 1'b1;
            check("eng_blk_valid", eng_blk_valid_out, exp_v);
            check("q_blk_rdy", q_blk_rdy_out, (m_phase == 2) && eng_blk_rdy_in[m_sel]);
            if (m_phase == 2) check("eng_blk", eng_blk_out, q_blk_in);
            check("busy", busy_out, m_busy);
            exp_v = '0;
            if (g >= 0) exp_v[g] = res_rdy_in;
            check("eng_res_rdy", eng_res_rdy_out, exp_v);
            if (g >= 0) begin
                check("res_valid", res_valid_out, eng_res_valid_in[g]);
                check("res_eng", res_eng_out, g);
                check("res_last", res_last_out, eng_res_last_in[g]);
                check("res_data", res_out, eng_res_in[g*RES_W +: RES_W]);
            end else begin
                check("res_valid", res_valid_out, 1'b0);
            end
            check("stat_cnt", stat_cnt_out, m_stat);
        end
        acc_res = eng_res_rdy_out & eng_res_valid_in;
        for (int i = 0; i < N; i++)
            if (eng_blk_valid_out[i] && eng_blk_rdy_in[i]) blk_seen[i]++;
        if (res_valid_out && res_rdy_in) begin
            out_eng.push_back(int'(res_eng_out));
            out_last.push_back(res_last_out);
            out_data.push_back(res_out);
        end
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            nb = m_busy & ~eng_done_in;
`ifdef ENGINE_ARRAY_STATS_EN
            m_stat = m_stats[stat_sel_in];
`endif
            case (m_phase)
                0: if (take_q) begin
                    m_sel = first_from(~m_busy, m_drr);
                    m_desc = q_info_in;
                    m_phase = 1;
                end
                1: if (eng_info_rdy_in[m_sel]) begin
                    nb[m_sel] = 1'b1;
                    m_stats[m_sel]++;
                    m_cnt = int'(m_desc[63:48]);
                    m_drr = (m_sel + 1) % N;
                    m_phase = (m_cnt == 0) ? 0 : 2;
                end
                default: if (q_blk_valid_in && eng_blk_rdy_in[m_sel]) begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 0;
                end
            endcase
            m_busy = nb;
            if (g >= 0 && eng_res_valid_in[g] && res_rdy_in) begin
                if (eng_res_last_in[g]) begin
                    m_locked = 0;
                    m_mrr = (g + 1) % N;
                end else begin
                    m_locked = 1;
                    m_grant = g;
                end
            end
        end
        #1;
    endtask

    task automatic dispatch(input int nqb);
        q_info_in = mk_desc(nqb);
        q_info_valid_in = 1;
        step();
        q_info_valid_in = 0;
    endtask

    initial begin
        int w [N];
        idle_inputs();
        m_reset();
        for (int i = 0; i < N; i++) blk_seen[i] = 0;
        rst = 1;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 0;
        step();
        check("reset_busy", busy_out, 4'b0000);
        check("reset_info_valid", eng_info_valid_out, 4'b0000);
        check("reset_res_valid", res_valid_out, 1'b0);

        // Three 2-block queries land on engines 0, 1, 2.
        eng_info_rdy_in = '1;
        eng_blk_rdy_in  = '1;
        for (int k = 0; k < 3; k++) begin
            dispatch(2);
            check("disp_sel", eng_info_valid_out, 4'b0001 << k);
            step();
            q_blk_valid_in = 1;
            q_blk_in = rand128();
            step();
            q_blk_in = rand128();
            step();
            q_blk_valid_in = 0;
            step();
        end
        check("disp_busy", busy_out, 4'b0111);
        for (int k = 0; k < 3; k++) check("disp_blks", blk_seen[k], 2);

        // Saturation, then a done pulse frees engine 2.
        dispatch(0);
        step();
        check("sat_busy", busy_out, 4'b1111);
        q_info_in = mk_desc(0);
        q_info_valid_in = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("sat_rdy", q_info_rdy_out, 1'b0);
        end
        eng_done_in = 4'b0100;
        step();
        eng_done_in = '0;
        check("sat_freed_rdy", q_info_rdy_out, 1'b1);
        step();
        q_info_valid_in = 0;
        check("sat_sel", eng_info_valid_out, 4'b0100);
        step();
        check("sat_busy2", busy_out, 4'b1111);

        // Zero-block query with a late descriptor ready.
        eng_done_in = '1;
        step();
        eng_done_in = '0;
        eng_info_rdy_in = '0;
        dispatch(0);
        for (int k = 0; k < 5; k++) begin
            check("zero_hold", eng_info_valid_out, 4'b1000);
            step();
        end
        eng_info_rdy_in = '1;
        step();
        check("zero_info_done", eng_info_valid_out, 4'b0000);
        check("zero_busy", busy_out, 4'b1000);
        q_blk_valid_in = 1;
        #1;
        check("zero_no_blk", q_blk_rdy_out, 1'b0);
        step();
        q_blk_valid_in = 0;
        check("zero_blks", blk_seen[3], 0);

        // Engines 1 and 3 race 4-word records with 50% downstream ready.
        eng_done_in = '1;
        step();
        eng_done_in = '0;
        for (int e = 0; e < N; e++) w[e] = (e == 1 || e == 3) ? 0 : 4;
        for (int c = 0; c < 40 && out_eng.size() < 8; c++) begin
            for (int e = 0; e < N; e++) begin
                eng_res_valid_in[e] = (w[e] < 4);
                eng_res_last_in[e]  = (w[e] == 3);
                eng_res_in[e*RES_W +: RES_W] = {96'(e), 32'(w[e])};
            end
            res_rdy_in = (c % 2 == 1);
            step();
            for (int e = 0; e < N; e++) if (acc_res[e]) w[e]++;
        end
        eng_res_valid_in = '0;
        eng_res_last_in = '0;
        res_rdy_in = 0;
        check("merge_words", out_eng.size(), 8);
        for (int i = 0; i < 8 && i < out_eng.size(); i++) begin
            check("merge_eng", out_eng[i], (i < 4) ? 1 : 3);
            check("merge_last", out_last[i], (i % 4) == 3);
            check("merge_data", out_data[i], {96'((i < 4) ? 1 : 3), 32'(i % 4)});
        end

        // Reset while forwarding blocks to engine 1.
        dispatch(0);
        step();
        eng_done_in = '1;
        step();
        eng_done_in = '0;
        dispatch(3);
        step();
        q_blk_valid_in = 1;
        q_blk_in = rand128();
        step();
        rst = 1;
        step();
        rst = 0;
        check("rst_blk_valid", eng_blk_valid_out, 4'b0000);
        check("rst_blk_rdy", q_blk_rdy_out, 1'b0);
        check("rst_info_valid", eng_info_valid_out, 4'b0000);
        check("rst_busy", busy_out, 4'b0000);
        q_blk_valid_in = 0;
        dispatch(1);
        check("rst_redispatch", eng_info_valid_out, 4'b0001);
        step();
        q_blk_valid_in = 1;
        step();
        q_blk_valid_in = 0;

        // Six dispatches after reset: engines 0,1,2,3,0,1.
        rst = 1;
        step();
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            dispatch(0);
            check("stat_sel_seq", eng_info_valid_out, 4'b0001 << (k % 4));
            step();
            eng_done_in = '1;
            step();
            eng_done_in = '0;
        end
        stat_sel_in = 2'd0;
        step();
`ifdef ENGINE_ARRAY_STATS_EN
        check("stat_eng0", stat_cnt_out, 32'd2);
`else
        check("stat_eng0", stat_cnt_out, 32'd0);
`endif
        stat_sel_in = 2'd3;
        step();
`ifdef ENGINE_ARRAY_STATS_EN
        check("stat_eng3", stat_cnt_out, 32'd1);
`else
        check("stat_eng3", stat_cnt_out, 32'd0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            q_info_valid_in = $urandom_range(0, 1) == 1;
            q_info_in = mk_desc($urandom_range(0, 3));
            q_blk_valid_in = $urandom_range(0, 1) == 1;
            q_blk_in = rand128();
            eng_info_rdy_in = N'($urandom);
            eng_blk_rdy_in = N'($urandom);
            for (int e = 0; e < N; e++) begin
                eng_done_in[e] = ($urandom_range(0, 15) == 0);
                eng_res_valid_in[e] = $urandom_range(0, 1) == 1;
                eng_res_last_in[e] = $urandom_range(0, 2) == 0;
                eng_res_in[e*RES_W +: RES_W] = rand128();
            end
            res_rdy_in = $urandom_range(0, 1) == 1;
            stat_sel_in = IW'($urandom);
            step();
        end
        rst = 0;
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
